// File: rtl/montgomery_pkg.sv
// Shared definitions for the Montgomery datapath: operand reader states,
// default operand width and a counter sizing helper.
package montgomery_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

   localparam int DEFAULT_OPERAND_WIDTH = 1024;

   // Bits needed to hold indices 0..count-1, never less than one bit.
   function automatic int counterWidth(input int count);
      return (count < 2) ? 1 : $clog2(count);
   endfunction

endpackage

// File: rtl/operand_bit_reader_bit_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag,
// shared by the iteration loops of the Montgomery datapath.
module bit_counter
   import montgomery_pkg::*;
#(
   parameter int               CNT_W    = 4,
   parameter logic [CNT_W-1:0] TERMINAL = '1
) (
   input  logic             clk,
   input  logic             restn,
   input  logic             clear_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o,
   output logic             terminal_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Clear wins over enable; the count holds once it reaches the terminal value.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i && !terminal_o) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!restn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o    = count_q;
   assign terminal_o = (count_q == TERMINAL);

endmodule

// File: rtl/operand_bit_reader.sv
// Bit-serial operand reader: latches a WIDTH-bit operand and streams it one bit
// per handshake. Define OPERAND_MSB_FIRST_EN to stream MSB first (default LSB first).
module operand_bit_reader
   import montgomery_pkg::*;
#(
   parameter int WIDTH = DEFAULT_OPERAND_WIDTH
) (
   input  logic                     clk,
   input  logic                     restn,
   input  logic [WIDTH-1:0]         in_number,
   input  logic                     load,
   input  logic                     bit_ready,
   output logic                     bit_out,
   output logic                     bit_valid,
   output logic [$clog2(WIDTH)-1:0] bit_index,
   output logic                     busy,
   output logic                     done
);

   localparam int               IDX_W    = counterWidth(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] opReg_q;
   logic [WIDTH-1:0] opShifted;
   logic             curBit;
   logic [IDX_W-1:0] count;
   logic [IDX_W-1:0] curIndex;
   logic             lastBit;
   logic             loadAccept;
   logic             advance;

   assign loadAccept = load && ((state_q == IDLE) || (state_q == DONE));
   assign advance    = (state_q == SHIFT) && bit_ready && !lastBit;

   bit_counter #(
      .CNT_W    (IDX_W),
      .TERMINAL (LAST_IDX)
   ) u_bit_counter (
      .clk        (clk),
      .restn      (restn),
      .clear_i    (loadAccept),
      .en_i       (advance),
      .count_o    (count),
      .terminal_o (lastBit)
   );

   // The counter always runs upward; MSB-first only changes which end is read
   // and how the position is reported.
`ifdef OPERAND_MSB_FIRST_EN
   assign opShifted = {opReg_q[WIDTH-2:0], 1'b0};
   assign curBit    = opReg_q[WIDTH-1];
   assign curIndex  = LAST_IDX - count;
`else
   assign opShifted = {1'b0, opReg_q[WIDTH-1:1]};
   assign curBit    = opReg_q[0];
   assign curIndex  = count;
`endif

   always_ff @(posedge clk) begin
      if (!restn) begin
         state_q <= IDLE;
         opReg_q <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (load) begin
                  opReg_q <= in_number;
                  state_q <= SHIFT;
               end else begin
                  state_q <= IDLE;
               end
            end
            SHIFT: begin
               if (bit_ready) begin
                  if (lastBit) begin
                     state_q <= DONE;
                  end else begin
                     opReg_q <= opShifted;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bit_valid = (state_q == SHIFT);
   assign busy      = (state_q == SHIFT);
   assign done      = (state_q == DONE);
   assign bit_out   = bit_valid & curBit;
   assign bit_index = bit_valid ? curIndex : '0;

endmodule

// File: tb/tb_operand_bit_reader.sv
// Self-checking bench for operand_bit_reader (WIDTH=8): table vectors, corner
// sequences and random traffic against a queue-based reference model.
module tb_operand_bit_reader;

   localparam int W  = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          restn;
   logic          load;
   logic          bit_ready;
   logic [W-1:0]  in_number;
   logic          bit_out;
   logic          bit_valid;
   logic [IW-1:0] bit_index;
   logic          busy;
   logic          done;

   int testsRun    = 0;
   int testsFailed = 0;
   int donesSeen   = 0;

   typedef struct {
      logic          b;
      logic [IW-1:0] idx;
   } beat_t;

   typedef struct {
      logic          ld;
      logic [W-1:0]  num;
      logic          rdy;
      logic          eValid;
      logic          eBit;
      logic [IW-1:0] eIdx;
      logic          eBusy;
      logic          eDone;
   } vec_t;

   // Reference model: the bits still owed to the consumer, plus a pending done.
   beat_t modelQ[$];
   logic  modelDone = 1'b0;

   always #5 clk = ~clk;

   operand_bit_reader #(.WIDTH(W)) dut (
      .clk       (clk),
      .restn     (restn),
      .in_number (in_number),
      .load      (load),
      .bit_ready (bit_ready),
      .bit_out   (bit_out),
      .bit_valid (bit_valid),
      .bit_index (bit_index),
      .busy      (busy),
      .done      (done)
   );

   // The k-th bit handed out for operand op, with its reported position.
   function automatic beat_t beatOf(input logic [W-1:0] op, input int k);
      beat_t r;
`ifdef OPERAND_MSB_FIRST_EN
      r.b   = op[W-1-k];
      r.idx = IW'(W - 1 - k);
`else
      r.b   = op[k];
      r.idx = IW'(k);
`endif
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic eValid, input logic eBit,
                              input logic [IW-1:0] eIdx, input logic eBusy, input logic eDone);
      testsRun++;
      if ({bit_valid, bit_out, bit_index, busy, done} !== {eValid, eBit, eIdx, eBusy, eDone}) begin
         testsFailed++;
         $display("[TB] FAIL %s @%0t: got valid=%0b bit=%0b idx=%0d busy=%0b done=%0b, expected valid=%0b bit=%0b idx=%0d busy=%0b done=%0b",
                  name, $time, bit_valid, bit_out, bit_index, busy, done,
                  eValid, eBit, eIdx, eBusy, eDone);
      end
   endtask

   // Drive one cycle of inputs, advance the model, clock, and compare.
   task automatic applyStimulus(input string name, input logic rn, input logic ld,
                                input logic [W-1:0] num, input logic rdy);
      restn     = rn;
      load      = ld;
      in_number = num;
      bit_ready = rdy;
      if (!rn) begin
         modelQ.delete();
         modelDone = 1'b0;
      end else if (modelQ.size() > 0) begin
         modelDone = 1'b0;
         if (rdy) begin
            void'(modelQ.pop_front());
            if (modelQ.size() == 0) modelDone = 1'b1;
         end
      end else begin
         modelDone = 1'b0;
         if (ld) begin
            for (int k = 0; k < W; k++) modelQ.push_back(beatOf(num, k));
         end
      end
      @(posedge clk);
      #1;
      if (done) donesSeen++;
      if (modelQ.size() > 0) checkOutput(name, 1'b1, modelQ[0].b, modelQ[0].idx, 1'b1, 1'b0);
      else                   checkOutput(name, 1'b0, 1'b0, '0, 1'b0, modelDone);
   endtask

   task automatic checkCount(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   vec_t  vecs[10];
   beat_t bt;

   initial begin
      restn     = 1'b0;
      load      = 1'b0;
      bit_ready = 1'b0;
      in_number = '0;

      // Reset then idle.
      for (int i = 0; i < 2; i++) applyStimulus("reset", 1'b0, 1'b0, 8'h00, 1'b0);
      donesSeen = 0;
      for (int i = 0; i < 5; i++) applyStimulus("idle", 1'b1, 1'b0, 8'h00, 1'b0);
      checkCount("idleNoDone", donesSeen, 0);

      // Full stream of 8'hB4 with the consumer always ready.
      bt      = beatOf(8'hB4, 0);
      vecs[0] = '{1'b1, 8'hB4, 1'b1, 1'b1, bt.b, bt.idx, 1'b1, 1'b0};
      for (int k = 1; k < W; k++) begin
         bt      = beatOf(8'hB4, k);
         vecs[k] = '{1'b0, 8'h00, 1'b1, 1'b1, bt.b, bt.idx, 1'b1, 1'b0};
      end
      vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
      vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         applyStimulus("streamModel", 1'b1, vecs[i].ld, vecs[i].num, vecs[i].rdy);
         checkOutput("streamVec", vecs[i].eValid, vecs[i].eBit, vecs[i].eIdx,
                     vecs[i].eBusy, vecs[i].eDone);
      end

      // Backpressure: consumer stalls three cycles on the first bit.
      applyStimulus("bpLoad", 1'b1, 1'b1, 8'h01, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus("bpStall", 1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < W; i++) applyStimulus("bpDrain", 1'b1, 1'b0, 8'h00, 1'b1);
      applyStimulus("bpIdle", 1'b1, 1'b0, 8'h00, 1'b1);

      // Load pulsed mid-stream must be ignored.
      donesSeen = 0;
      applyStimulus("midLoad0", 1'b1, 1'b1, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus("midRun", 1'b1, 1'b0, 8'h00, 1'b1);
      applyStimulus("midPulse", 1'b1, 1'b1, 8'hFF, 1'b1);
      for (int i = 0; i < W; i++) applyStimulus("midDrain", 1'b1, 1'b0, 8'hFF, 1'b1);
      checkCount("midSingleDone", donesSeen, 1);

      // Back-to-back: new operand loaded in the DONE cycle.
      applyStimulus("b2bLoad55", 1'b1, 1'b1, 8'h55, 1'b1);
      for (int i = 0; i < W; i++) applyStimulus("b2bRun55", 1'b1, 1'b0, 8'h00, 1'b1);
      applyStimulus("b2bLoadAA", 1'b1, 1'b1, 8'hAA, 1'b1);
      for (int i = 0; i < W + 1; i++) applyStimulus("b2bRunAA", 1'b1, 1'b0, 8'h00, 1'b1);

      // Reset mid-operation abandons the stream without a done pulse.
      applyStimulus("rstLoad", 1'b1, 1'b1, 8'hA5, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus("rstRun", 1'b1, 1'b0, 8'h00, 1'b1);
      donesSeen = 0;
      applyStimulus("rstHit", 1'b0, 1'b1, 8'hFF, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus("rstIdle", 1'b1, 1'b0, 8'h00, 1'b1);
      checkCount("rstNoDone", donesSeen, 0);
      applyStimulus("rstFresh", 1'b1, 1'b1, 8'h01, 1'b1);
      for (int i = 0; i < W + 1; i++) applyStimulus("rstDrain", 1'b1, 1'b0, 8'h00, 1'b1);

      // Random traffic against the reference model.
      for (int i = 0; i < 800; i++) begin
         applyStimulus("random",
                       ($urandom_range(0, 99) != 0),
                       ($urandom_range(0, 3) == 0),
                       W'($urandom),
                       ($urandom_range(0, 3) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/operand_bit_reader.md
# operand_bit_reader

Bit-serial reader for the Montgomery datapath: latches a WIDTH-bit operand and presents it one bit per handshake, LSB first by default, so the multiplier loop can consume a_i each iteration. It is the consuming counterpart of the left-shift operand register. Consecutive bits stream at one per cycle while the consumer is ready, and a one-cycle done pulse follows the last bit.

## Interface
- WIDTH, 1024, operand width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- restn  input  1  synchronous active-low reset.
- in_number  input  WIDTH  operand, sampled on an accepted load.
- load  input  1  load request; accepted only in IDLE or DONE.
- bit_ready  input  1  consumer accepts bit_out this cycle.
- bit_out  output  1  current operand bit.
- bit_valid  output  1  bit_out/bit_index are meaningful.
- bit_index  output  $clog2(WIDTH)  position of bit_out within the operand.
- busy  output  1  high in SHIFT.
- done  output  1  one-cycle pulse after the last bit is accepted.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: outputs quiet. load=1 → capture in_number into an internal WIDTH-bit register, clear the counter, go to SHIFT.
- SHIFT: bit_valid=1, busy=1, bit_out=reg[0] (LSB-first), bit_index=counter.
  - bit_ready=0 → hold all state.
  - bit_ready=1 and counter<WIDTH-1 → shift reg right by 1 with zero fill, increment counter.
  - bit_ready=1 and counter=WIDTH-1 → go to DONE.
- DONE: done=1 for exactly one cycle, bit_valid=0, busy=0.
  - load=1 → capture and go to SHIFT, giving back-to-back operands.
  - Otherwise → IDLE.
- load is ignored in SHIFT; the operand register and counter are unaffected.
- in_number is not used outside the load cycle.

## Timing
- Reset (restn=0 at a clock edge) sets:
  - state=IDLE.
  - Operand register and counter = 0.
  - Outputs bit_out=0, bit_valid=0, bit_index=0, busy=0, done=0.
- Reset overrides load and abandons any operation in progress; no done pulse is issued.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Load accepted at edge N → bit_valid=1 with bit 0 from edge N+1.
- With bit_ready held high, bit k is presented in cycle N+1+k.
- Last bit at N+WIDTH; done is high during N+WIDTH+1.
- A full operand takes WIDTH+1 cycles from load to done.
- Counter never wraps: it stops at WIDTH-1.

## Configuration
- OPERAND_MSB_FIRST_EN defined:
  - bit_out=reg[WIDTH-1]; the register shifts left with zero fill.
  - bit_index counts down from WIDTH-1 to 0; the final handshake is at index 0.
- OPERAND_MSB_FIRST_EN undefined: LSB-first behaviour as above.
- Cycle counts and the handshake are identical in both builds.

## Structure
- Shared package montgomery_pkg holds:
  - The state enum (IDLE/SHIFT/DONE).
  - Default operand width constant (1024).
  - Counter-width helper.
- The bit counter is a natural sub-module, bit_counter: load-clear, enable-increment, terminal-count flag, parameterised width and terminal value. It is reused by other iteration loops.
- Everything else stays in one module.

## Test plan
- Reset then idle: restn=0 for 2 cycles, then load=0 for 5 cycles → all outputs 0, busy=0, no done.
- Full stream with WIDTH=8: in_number=8'hB4, bit_ready=1 → bit_out sequence 0,0,1,0,1,1,0,1, bit_index 0..7, done exactly 9 cycles after load.
- Backpressure with WIDTH=8: in_number=8'h01, bit_ready low for 3 cycles at index 0 → bit_out=1 and bit_index=0 held; stream resumes; done delayed by 3 cycles.
- Load ignored mid-stream: pulse load with in_number=8'hFF at index 3 of 8'h00 → all 8 bits 0, single done.
- Back-to-back: load 8'hAA in the DONE cycle of a previous 8'h55 stream → SHIFT re-entered next cycle with bit_out=0, index 0, no idle gap.
- Reset mid-operation: restn=0 at index 4 → next cycle bit_valid=0, busy=0, done never pulses; a fresh load of 1024'h1 yields bit_out=1 at index 0.
